bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL provide parameter BIN_W, default 16, binary input width (>= 4).
REQ-002 SHALL provide parameter NUM_DIG, default 5, BCD output digit count.
REQ-003 SHALL fail elaboration when NUM_DIG < bin2bcd_pkg::min_digits(BIN_W), i.e. ceil(BIN_W*log10(2)).
REQ-004 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: in_valid  input  1  request carrying a conversion operand.
REQ-007 SHALL have ports: in_ready  output  1  block can accept an operand.
REQ-008 SHALL have ports: b_in  input  BIN_W  binary operand.
REQ-009 SHALL have ports: signed_mode  input  1  treat b_in as two's complement; sampled with b_in.
REQ-010 SHALL have ports: out_valid  output  1  result available.
REQ-011 SHALL have ports: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have ports: bcd_out  output  4*NUM_DIG  packed BCD digits, digit 0 in [3:0].
REQ-013 SHALL have ports: neg_out  output  1  result sign, 1 = negative operand.
REQ-014 SHALL have ports: busy  output  1  conversion in progress.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL equal (state == IDLE); accept = in_valid & in_ready at a rising edge.
REQ-017 On accept, magnitude register SHALL load |b_in| if signed_mode & b_in[BIN_W-1], else b_in; neg_out SHALL load that sign condition; digit register SHALL clear; bit counter SHALL load BIN_W; state -> SHIFT.
REQ-018 -2^(BIN_W-1) in signed mode SHALL convert to magnitude 2^(BIN_W-1) without overflow.
REQ-019 Each SHIFT cycle SHALL add 3 to every digit >= 5, then shift {digits, magnitude} left one bit as a single register update; counter decrements.
REQ-020 Add-3 adjustment SHALL NOT occur on the final shift step.
REQ-021 After the BIN_W-th shift, state SHALL -> DONE; out_valid rises exactly BIN_W cycles after the accept edge.
REQ-022 busy SHALL equal (state == SHIFT).
REQ-023 In DONE, out_valid = 1, and bcd_out and neg_out SHALL stay stable until out_valid & out_ready.
REQ-024 On the output handshake, state SHALL -> IDLE; in_ready rises the following cycle; no new accept occurs in DONE.
REQ-025 in_valid asserted during SHIFT or DONE SHALL be ignored, with no corruption of the result.
REQ-026 out_ready outside DONE SHALL have no effect.
REQ-027 Zero input SHALL yield bcd_out = 0 and neg_out = 0; signed_mode with a non-negative operand SHALL match unsigned conversion.
REQ-028 Minimum period SHALL be BIN_W + 2 cycles per conversion with out_ready tied high.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, bcd_out = 0, neg_out = 0, out_valid = 0, busy = 0, in_ready = 1 after release.
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL discard the conversion; no out_valid follows release until a new accept.
REQ-031 Counter and magnitude register SHALL reset to 0.

Structure
REQ-032 Package bin2bcd_pkg SHALL hold the state enum type and the min_digits() constant function.
REQ-033 Sub-module bcd_digit_adj SHALL implement the 4-bit add-3-if->=5 cell, instantiated NUM_DIG times.
REQ-034 Counter width SHALL be $clog2(BIN_W+1).

Verification
REQ-035 BIN_W=8, NUM_DIG=3, unsigned b_in=255 -> out_valid 8 cycles after accept, bcd_out=0x255, neg_out=0.
REQ-036 BIN_W=16, NUM_DIG=5: 65535 -> 0x65535; 0 -> 0x00000; 1000 -> 0x01000.
REQ-037 BIN_W=8 signed: 0x80 -> 0x128 neg=1; 0xFF -> 0x001 neg=1; 0x7F -> 0x127 neg=0.
REQ-038 out_ready held low 6 cycles in DONE -> bcd_out stable, in_ready = 0; in_valid pulses ignored; handshake -> IDLE next cycle.
REQ-039 rst_n pulsed low at SHIFT cycle 4 -> outputs zero immediately, no out_valid after release; next operand 42 -> 0x042.
REQ-040 BIN_W=8 exhaustive sweep of 0..255 in both modes, back-to-back, checked against a reference model.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ceil(w*log10(2)); w*log10(2) is never an integer for w > 0, so rounding up is exact
  function automatic int unsigned min_digits(input int unsigned w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready handshakes
// and optional two's-complement operand handling.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W   = 16,
  parameter int unsigned NUM_DIG = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_W-1:0]     b_in,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NUM_DIG-1:0] bcd_out,
  output logic                 neg_out,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned DIG_W = 4 * NUM_DIG;

  if (BIN_W < 4) begin : g_bad_width
    $error("bin2bcd_seq: BIN_W must be at least 4");
  end
  if (NUM_DIG < min_digits(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: NUM_DIG too small for BIN_W");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   mag_q;
  logic [DIG_W-1:0]   dig_q;
  logic               neg_q;

  logic               accept;
  logic               op_neg;
  logic [BIN_W-1:0]   op_mag;
  logic [DIG_W+BIN_W-1:0] shifted;
  logic [DIG_W-1:0]   dig_sh;
  logic [DIG_W-1:0]   dig_adj;
  logic [DIG_W-1:0]   dig_nx;
  logic [BIN_W-1:0]   mag_sh;
  logic               last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign last_step = (cnt_q == CNT_W'(1));

  // Two's-complement negate in BIN_W bits: -2^(BIN_W-1) maps to 2^(BIN_W-1) unsigned
  always_comb begin
    op_neg = signed_mode & b_in[BIN_W-1];
    op_mag = b_in;
    if (op_neg) op_mag = ~b_in + 1'b1;
  end

  // Shift first, then correct the freshly shifted digits; skipping the correction on
  // the last step is equivalent to correct-then-shift with a no-op first correction.
  assign shifted = {dig_q, mag_q} << 1;
  assign dig_sh  = shifted[DIG_W+BIN_W-1 -: DIG_W];
  assign mag_sh  = shifted[BIN_W-1:0];

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (dig_sh[4*i +: 4]),
      .q (dig_adj[4*i +: 4])
    );
  end

  assign dig_nx = last_step ? dig_sh : dig_adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mag_q <= '0;
      dig_q <= '0;
      neg_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= CNT_W'(BIN_W);
      mag_q <= op_mag;
      dig_q <= '0;
      neg_q <= op_neg;
    end else if (busy) begin
      cnt_q <= cnt_q - 1'b1;
      mag_q <= mag_sh;
      dig_q <= dig_nx;
    end
  end

  assign bcd_out = dig_q;
  assign neg_out = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed, randomized and exhaustive 8-bit sweeps
// against a decimal-digit reference model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv8, ir8, sm8, ov8, or8, neg8, busy8;
  logic [7:0]  b8;
  logic [11:0] bcd8;
  logic        iv16, ir16, sm16, ov16, or16, neg16, busy16;
  logic [15:0] b16;
  logic [19:0] bcd16;

  bin2bcd_seq #(.BIN_W(8), .NUM_DIG(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .b_in(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .bcd_out(bcd8),
    .neg_out(neg8), .busy(busy8)
  );

  bin2bcd_seq #(.BIN_W(16), .NUM_DIG(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .b_in(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .bcd_out(bcd16),
    .neg_out(neg16), .busy(busy16)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint unsigned ref_mag(input longint unsigned v, input int w, input logic s);
    if (s && v >= (64'd1 << (w - 1))) return (64'd1 << w) - v;
    return v;
  endfunction

  // exp_const of all ones means "model only"
  task automatic run8(input logic [7:0] v, input logic s, input bit stall, input logic [31:0] exp_const);
    int cyc;
    longint unsigned m;
    logic [31:0] held;
    m = ref_mag(64'(v), 8, s);
    cyc = 0;
    while (ir8 !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("ready8", 32'(ir8), 32'd1);
    iv8 = 1'b1; b8 = v; sm8 = s;
    @(posedge clk); #1;
    iv8 = 1'b0; b8 = 8'($urandom); sm8 = 1'($urandom);
    check("busy8", 32'(busy8), 32'd1);
    cyc = 0;
    while (ov8 !== 1'b1 && cyc < 40) begin
      if (stall) begin iv8 = cyc[0]; or8 = (cyc < 7); end
      @(posedge clk); #1; cyc++;
    end
    check("lat8", 32'(cyc), 32'd8);
    check("bcd8", 32'(bcd8), ref_bcd(m));
    check("neg8", 32'(neg8), 32'(s & v[7]));
    if (exp_const != 32'hFFFF_FFFF) check("dir8", 32'(bcd8), exp_const);
    if (stall) begin
      held = 32'(bcd8);
      for (int k = 0; k < 6; k++) begin
        iv8 = ~iv8; b8 = 8'($urandom); or8 = 1'b0;
        @(posedge clk); #1;
        check("hold8", {bcd8, ov8, ir8}, {held[11:0], 2'b10});
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check("idle8", 32'({ov8, ir8, busy8}), 32'b010);
  endtask

  task automatic run16(input logic [15:0] v, input logic s, input logic [31:0] exp_const);
    int cyc;
    longint unsigned m;
    m = ref_mag(64'(v), 16, s);
    cyc = 0;
    while (ir16 !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("ready16", 32'(ir16), 32'd1);
    iv16 = 1'b1; b16 = v; sm16 = s;
    @(posedge clk); #1;
    iv16 = 1'b0; b16 = 16'($urandom);
    cyc = 0;
    while (ov16 !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
    check("lat16", 32'(cyc), 32'd16);
    check("bcd16", 32'(bcd16), ref_bcd(m));
    check("neg16", 32'(neg16), 32'(s & v[15]));
    if (exp_const != 32'hFFFF_FFFF) check("dir16", 32'(bcd16), exp_const);
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    check("idle16", 32'({ov16, ir16}), 32'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    iv8 = 0; b8 = 0; sm8 = 0; or8 = 0;
    iv16 = 0; b16 = 0; sm16 = 0; or16 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst8", 32'({bcd8, neg8, ov8, busy8, ir8}), 32'b1);
    check("rst16", 32'({bcd16, neg16, ov16, busy16, ir16}), 32'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8(8'd255, 1'b0, 1'b0, 32'h255);
    run8(8'h80, 1'b1, 1'b0, 32'h128);
    run8(8'hFF, 1'b1, 1'b0, 32'h001);
    run8(8'h7F, 1'b1, 1'b0, 32'h127);
    run8(8'd0, 1'b1, 1'b0, 32'h000);
    run16(16'd65535, 1'b0, 32'h65535);
    run16(16'd0, 1'b0, 32'h00000);
    run16(16'd1000, 1'b0, 32'h01000);
    run16(16'h8000, 1'b1, 32'h32768);

    // Output stall with in_valid/out_ready noise during SHIFT and DONE
    run8(8'd153, 1'b0, 1'b1, 32'h153);

    // Reset in the middle of a signed conversion
    iv8 = 1'b1; b8 = 8'h80; sm8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst", 32'({bcd8, neg8, ov8, busy8, ir8}), 32'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ov8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
    end
    check("noout", 32'(seen), 32'd0);
    run8(8'd42, 1'b0, 1'b0, 32'h042);

    for (int i = 0; i < 30; i++) run16(16'($urandom), 1'($urandom), 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) run8(8'($urandom), 1'($urandom), 1'b1, 32'hFFFF_FFFF);

    for (int s = 0; s < 2; s++)
      for (int v = 0; v < 256; v++) run8(8'(v), 1'(s), 1'b0, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
